// File: rtl/swarm_pkg.sv
// Shared swarm types and task-enqueue-arbiter register map.
// Core indices are 4 bits wide so that up to 16 cores can be addressed.
package swarm_pkg;
  localparam int CORE_W = 4;

  typedef logic [CORE_W-1:0] core_id_t;
  typedef logic [7:0]        cq_slice_slot_t;
  typedef logic [3:0]        child_id_t;

  typedef struct packed {
    logic [31:0] ts;
    logic [15:0] hint;
    logic [3:0]  ttype;
    logic [31:0] arg;
  } task_t;

  localparam logic [15:0] TEA_QUERY_CORE = 16'h0000;
  localparam logic [15:0] TEA_NUM_GRANTS = 16'h0004;
  localparam logic [15:0] TEA_NUM_STALLS = 16'h0008;
  localparam logic [15:0] TEA_TILE_ID    = 16'h000C;

  // Round-robin successor of a winner index, wrapping at n.
  function automatic core_id_t rr_next(input core_id_t idx, input int n);
    if (int'(idx) == n - 1) begin
      return '0;
    end else begin
      return idx + core_id_t'(1);
    end
  endfunction
endpackage

// File: rtl/reg_bus_t.sv
// Simple register bus: single-cycle write, read data returned one cycle after arvalid.
interface reg_bus_t;
  logic        wvalid;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        arvalid;
  logic [15:0] araddr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (input wvalid, waddr, wdata, arvalid, araddr, output rvalid, rdata);
  modport host   (output wvalid, waddr, wdata, arvalid, araddr, input rvalid, rdata);
endinterface

// File: rtl/task_enq_arb_rr_arbiter.sv
// Round-robin arbiter: lowest request at or above ptr wins, otherwise the
// lowest request overall (masked / unmasked priority encoder pair).
module rr_arbiter
  import swarm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  core_id_t     ptr,
  output logic [N-1:0] grant,
  output core_id_t     idx,
  output logic         any
);

  logic [N-1:0] masked_s;

  function automatic core_id_t lowest_idx(input logic [N-1:0] v);
    core_id_t r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = core_id_t'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Keep only requests at or above the round-robin pointer.
  always_comb begin
    masked_s = '0;
    for (int i = 0; i < N; i++) begin
      masked_s[i] = req[i] & (core_id_t'(i) >= ptr);
    end
  end

  // Select the winner and build the one-hot grant.
  always_comb begin
    idx   = '0;
    any   = |req;
    grant = '0;
    if (|masked_s) begin
      idx = lowest_idx(masked_s);
    end else begin
      idx = lowest_idx(req);
    end
    if (any) begin
      grant = {{(N-1){1'b0}}, 1'b1} << idx;
    end else begin
      grant = '0;
    end
  end
endmodule

// File: rtl/task_enq_arb.sv
// Arbitrates per-core task enqueue requests into a single registered output
// slot toward the task unit, with grant/stall statistics on the register bus.
module task_enq_arb
  import swarm_pkg::*;
#(
  parameter int N_CORES = 8,
  parameter int TILE_ID = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_CORES-1:0]   in_valid,
  input  task_t                in_data [N_CORES],
  input  logic [N_CORES-1:0]   in_untied,
  input  cq_slice_slot_t       in_slot [N_CORES],
  input  child_id_t            in_child_id [N_CORES],
  output logic [N_CORES-1:0]   in_ready,
  output logic                 out_valid,
  output task_t                out_data,
  output logic                 out_untied,
  output cq_slice_slot_t       out_slot,
  output child_id_t            out_child_id,
  output core_id_t             out_core,
  input  logic                 out_ready,
  reg_bus_t.master             reg_bus
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic               slot_free_s;
  logic [N_CORES-1:0] req_s;
  logic [N_CORES-1:0] grant_s;
  core_id_t           win_idx_s;
  logic               win_any_s;
  core_id_t           ptr_r;
  logic [31:0]        grants_r [N_CORES];
  logic [31:0]        stalls_r;
  core_id_t           query_core_r;
  logic [31:0]        rd_mux_s;

  // Requests are masked during reset so in_ready stays low.
  assign slot_free_s = !out_valid | out_ready;
  assign req_s       = in_valid & {N_CORES{slot_free_s & rstn}};
  assign in_ready    = grant_s;

  rr_arbiter #(.N(N_CORES)) u_arb (
    .req   (req_s),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (win_idx_s),
    .any   (win_any_s)
  );

  // Output slot and round-robin pointer; payload is don't-care while empty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      ptr_r     <= '0;
    end else if (slot_free_s) begin
      out_valid <= win_any_s;
      if (win_any_s) begin
        out_data     <= in_data[win_idx_s[IDX_W-1:0]];
        out_untied   <= in_untied[win_idx_s[IDX_W-1:0]];
        out_slot     <= in_slot[win_idx_s[IDX_W-1:0]];
        out_child_id <= in_child_id[win_idx_s[IDX_W-1:0]];
        out_core     <= win_idx_s;
        ptr_r        <= rr_next(win_idx_s, N_CORES);
      end
    end
  end

  // Grant and stall statistics, wrapping at 32 bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_CORES; i++) begin
        grants_r[i] <= 32'd0;
      end
      stalls_r <= 32'd0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (grant_s[i]) begin
          grants_r[i] <= grants_r[i] + 32'd1;
        end
      end
      if ((|in_valid) && !slot_free_s) begin
        stalls_r <= stalls_r + 32'd1;
      end
    end
  end

  // Register read mux; out-of-range query cores read as zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (reg_bus.araddr)
      TEA_QUERY_CORE: rd_mux_s = 32'(query_core_r);
      TEA_NUM_GRANTS: begin
        if ({1'b0, query_core_r} < 5'(N_CORES)) begin
          rd_mux_s = grants_r[query_core_r[IDX_W-1:0]];
        end else begin
          rd_mux_s = 32'd0;
        end
      end
      TEA_NUM_STALLS: rd_mux_s = stalls_r;
      TEA_TILE_ID:    rd_mux_s = 32'(TILE_ID);
      default:        rd_mux_s = 32'd0;
    endcase
  end

  // Register bus write decode and one-cycle read response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      query_core_r   <= '0;
      reg_bus.rvalid <= 1'b0;
      reg_bus.rdata  <= 32'd0;
    end else begin
      reg_bus.rvalid <= reg_bus.arvalid;
      if (reg_bus.arvalid) begin
        reg_bus.rdata <= rd_mux_s;
      end
      if (reg_bus.wvalid && (reg_bus.waddr == TEA_QUERY_CORE)) begin
        query_core_r <= core_id_t'(reg_bus.wdata);
      end
    end
  end
endmodule

// File: tb/tb_task_enq_arb.sv
// Directed bench for task_enq_arb: arbitration order, back-pressure,
// reset behaviour and statistics registers, with hand-computed expectations.
module tb_task_enq_arb;
  import swarm_pkg::*;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   in_valid;
  task_t          in_data [N];
  logic [N-1:0]   in_untied;
  cq_slice_slot_t in_slot [N];
  child_id_t      in_child_id [N];
  logic [N-1:0]   in_ready;
  logic           out_valid;
  task_t          out_data;
  logic           out_untied;
  cq_slice_slot_t out_slot;
  child_id_t      out_child_id;
  core_id_t       out_core;
  logic           out_ready;

  int total = 0;
  int fails = 0;

  reg_bus_t rb ();

  task_enq_arb #(.N_CORES(N), .TILE_ID(0)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_untied    (in_untied),
    .in_slot      (in_slot),
    .in_child_id  (in_child_id),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_untied   (out_untied),
    .out_slot     (out_slot),
    .out_child_id (out_child_id),
    .out_core     (out_core),
    .out_ready    (out_ready),
    .reg_bus      (rb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    rb.wvalid = 1'b1;
    rb.waddr  = a;
    rb.wdata  = d;
    tick();
    rb.wvalid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    rb.arvalid = 1'b1;
    rb.araddr  = a;
    tick();
    chk({tag, "_rvalid"}, 32'(rb.rvalid), 32'd1);
    chk(tag, rb.rdata, exp);
    rb.arvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      in_data[i].ts    = 32'h1000 + 32'(i);
      in_data[i].hint  = 16'hA000 + 16'(i);
      in_data[i].ttype = 4'(i);
      in_data[i].arg   = 32'hC0DE0000 + 32'(i);
      in_slot[i]       = 8'h30 + 8'(i);
      in_child_id[i]   = 4'(15 - i);
    end
    in_untied  = 8'hAA;
    rb.wvalid  = 1'b0;
    rb.waddr   = 16'h0000;
    rb.wdata   = 32'd0;
    rb.arvalid = 1'b0;
    rb.araddr  = 16'h0000;
    out_ready  = 1'b1;
    rstn       = 1'b0;
    in_valid   = 8'hFF;
    #1;

    // Reset state, with all cores requesting
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ptr", 32'(dut.ptr_r), 32'd0);
    chk("rst_rvalid", 32'(rb.rvalid), 32'd0);

    // Only core 3 requests
    rstn = 1'b1;
    in_valid = 8'h08;
    #1;
    chk("c3_in_ready", 32'(in_ready), 32'h08);
    tick();
    in_valid = 8'h00;
    chk("c3_out_valid", 32'(out_valid), 32'd1);
    chk("c3_out_core", 32'(out_core), 32'd3);
    chk("c3_ts", out_data.ts, 32'h1003);
    chk("c3_arg", out_data.arg, 32'hC0DE0003);
    chk("c3_slot", 32'(out_slot), 32'h33);
    chk("c3_child", 32'(out_child_id), 32'hC);
    chk("c3_untied", 32'(out_untied), 32'd1);
    chk("c3_ptr", 32'(dut.ptr_r), 32'd4);
    tick();
    chk("c3_drain", 32'(out_valid), 32'd0);

    // All cores request continuously from ptr=0
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_core", 32'(out_core), 32'(k % 8));
    end
    in_valid = 8'h00;
    tick();
    chk("rr_drain", 32'(out_valid), 32'd0);

    // Back-pressure: output full, out_ready low for 5 cycles
    out_ready = 1'b0;
    in_valid = 8'h04;
    tick();
    chk("bp_load_valid", 32'(out_valid), 32'd1);
    chk("bp_load_core", 32'(out_core), 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", 32'(in_ready), 32'h00);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_core", 32'(out_core), 32'd2);
      chk("bp_ts", out_data.ts, 32'h1002);
    end
    in_valid = 8'h00;
    rd("bp_stalls", TEA_NUM_STALLS, 32'd5);
    out_ready = 1'b1;
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Pointer at 7 with cores 2 and 7 requesting
    in_valid = 8'h40;
    tick();
    in_valid = 8'h00;
    chk("wrap_ptr7", 32'(dut.ptr_r), 32'd7);
    in_valid = 8'h84;
    #1;
    chk("wrap_rdy7", 32'(in_ready), 32'h80);
    tick();
    chk("wrap_core7", 32'(out_core), 32'd7);
    in_valid = 8'h04;
    #1;
    chk("wrap_rdy2", 32'(in_ready), 32'h04);
    tick();
    in_valid = 8'h00;
    chk("wrap_core2", 32'(out_core), 32'd2);
    chk("wrap_ptr3", 32'(dut.ptr_r), 32'd3);
    tick();
    chk("wrap_drain", 32'(out_valid), 32'd0);

    // Reset while an entry is held
    in_valid = 8'h01;
    tick();
    chk("mid_valid", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'h00);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ptr", 32'(dut.ptr_r), 32'd0);
    rstn = 1'b1;
    in_valid = 8'h00;
    tick();
    chk("mid_no_replay", 32'(out_valid), 32'd0);
    rd("mid_stalls", TEA_NUM_STALLS, 32'd0);
    rd("mid_grants0", TEA_NUM_GRANTS, 32'd0);

    // Ten back-to-back grants to core 5, then query its counter
    in_valid = 8'h20;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("c5_valid", 32'(out_valid), 32'd1);
      chk("c5_core", 32'(out_core), 32'd5);
    end
    in_valid = 8'h00;
    wr(TEA_QUERY_CORE, 32'd5);
    rd("c5_query", TEA_QUERY_CORE, 32'd5);
    rd("c5_grants", TEA_NUM_GRANTS, 32'd10);
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/task_enq_arb.md
TASK_ENQ_ARB -- requirements
Module: task_enq_arb

Interface
REQ-001 SHALL have parameter N_CORES, default 8, number of core enqueue ports, legal range 2..16.
REQ-002 SHALL have parameter TILE_ID, default 0, tile index for debug display only.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, N_CORES bits: per-core enqueue request.
REQ-006 SHALL have port in_data, input, N_CORES x task_t: per-core task payload.
REQ-007 SHALL have port in_untied, input, N_CORES bits: per-core untied flag.
REQ-008 SHALL have port in_slot, input, N_CORES x cq_slice_slot_t: parent CQ slot.
REQ-009 SHALL have port in_child_id, input, N_CORES x child_id_t: parent child index.
REQ-010 SHALL have port in_ready, output, N_CORES bits: per-core accept.
REQ-011 SHALL have port out_valid, output, 1 bit: registered request to the task unit.
REQ-012 SHALL have port out_data, output, task_t: registered payload.
REQ-013 SHALL have port out_untied, output, 1 bit: registered untied flag.
REQ-014 SHALL have port out_slot, output, cq_slice_slot_t: registered parent slot.
REQ-015 SHALL have port out_child_id, output, child_id_t: registered child index.
REQ-016 SHALL have port out_core, output, core_id_t: index of the originating core.
REQ-017 SHALL have port out_ready, input, 1 bit: task unit accept.
REQ-018 SHALL have port reg_bus, reg_bus_t.master: statistics read and configuration.

Function
REQ-019 SHALL hold a one-entry output register; slot_free = !out_valid | out_ready.
REQ-020 SHALL choose at most one winner per cycle, and only when slot_free and at least one in_valid is set.
REQ-021 SHALL drive in_ready[i]=1 only for the winner, combinationally, in the same cycle; all other bits SHALL be 0.
REQ-022 SHALL load the winner's data, untied, slot, child_id and index into the output register on the next edge and set out_valid.
REQ-023 SHALL clear out_valid on out_valid & out_ready when no new winner exists in that cycle.
REQ-024 SHALL sustain one transfer per cycle when out_ready is held high (zero-bubble).
REQ-025 SHALL hold every output stable while out_valid & !out_ready.
REQ-026 SHALL arbitrate round-robin: the search starts at ptr, ptr SHALL update to (winner+1) mod N_CORES on grant, and ptr SHALL NOT change when there is no grant.
REQ-027 SHALL wrap ptr from N_CORES-1 to 0.
REQ-028 SHALL ignore in_valid bits at or above N_CORES; no X propagates from them.
REQ-029 SHALL count per-core grants in 32-bit wrapping counters, plus a 32-bit stall counter that increments on cycles with any in_valid & !slot_free.
REQ-030 SHALL latch query_core on a reg_bus write to TEA_QUERY_CORE.
REQ-031 SHALL return grants[query_core] for a read of TEA_NUM_GRANTS and the stall count for a read of TEA_NUM_STALLS, with rvalid one cycle after arvalid.

Reset
REQ-032 SHALL on !rstn clear out_valid to 0, ptr to 0, all counters to 0, query_core to 0 and reg_bus.rvalid to 0.
REQ-033 SHALL drive in_ready to 0 during reset.
REQ-034 SHALL leave out_data, out_untied, out_slot, out_child_id and out_core don't-care while out_valid=0.
REQ-035 SHALL discard an in-flight entry on reset mid-transfer; the entry is not replayed.

Structure
REQ-036 SHALL take task_t, cq_slice_slot_t, child_id_t, core_id_t and the TEA_* register addresses from the swarm package.
REQ-037 SHALL place arbitration in one sub-module, rr_arbiter (N-bit request, ptr in, one-hot grant out, encoded index out), implemented as a masked and unmasked priority encoder pair.

Verification
REQ-038 Bench SHALL cover: only core 3 requests, out_ready=1 -> in_ready[3]=1 in the same cycle, out_valid=1 next cycle with out_core=3, and ptr=4.
REQ-039 Bench SHALL cover: all 8 cores request continuously, out_ready=1 -> out_core sequence 0,1,...,7,0 on consecutive cycles with no bubble.
REQ-040 Bench SHALL cover: out_ready=0 for 5 cycles with the output full -> outputs stable, in_ready=0, stall counter +5.
REQ-041 Bench SHALL cover: ptr=7 with requests from cores 2 and 7 -> 7 granted first, then 2, and ptr ends at 3.
REQ-042 Bench SHALL cover: rstn asserted while out_valid=1 -> next cycle out_valid=0, ptr=0 and counters 0.
REQ-043 Bench SHALL cover: 10 grants to core 5, write 5 to TEA_QUERY_CORE, read TEA_NUM_GRANTS -> rdata=10 one cycle after arvalid.
